echo_mix_stage: RTL and testbench

- Downstream consumer of the selectable tap delay lines.
- Takes the undelayed (dry) sample and the selected delayed (wet) sample, and produces a registered weighted mix: out = dry·(8−g) + wet·g, scaled by 1/8 and rounded.
- Tap changes would otherwise cause an audible or visible discontinuity. On a tap change the block mutes the wet path for a fixed number of samples, then ramps the wet gain back up to the programmed value.
- Sits between the tap multiplexer and the output pins.

---
 rtl/echo_mix_stage.sv | 141 ++++++++++++++
 tb/tb_echo_mix_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_mix_stage.sv
// echo_mix_stage: weighted dry/wet mix with mute on tap change; 1-cycle latency, no backpressure.
// Optional wet fade-in ramp after mute is built when ECHO_FADE_EN is defined.
module echo_mix_stage #(
    parameter int MUTE_SAMPLES = 16,
    parameter int FADE_STEP    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [7:0] dry_in,
    input  logic [7:0] wet_in,
    input  logic [1:0] tap_sel,
    input  logic [3:0] mix_gain,
    output logic [7:0] mix_out,
    output logic       mix_valid,
    output logic       muted
);
    localparam int            MW        = $clog2(MUTE_SAMPLES + 1);
    localparam logic [MW-1:0] MUTE_LOAD = MW'(MUTE_SAMPLES);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUTE = 2'd1,
        ST_FADE = 2'd2
    } state_t;

    state_t        r_state;
    logic [1:0]    r_tap_q;
    logic [MW-1:0] r_mute_cnt;
    logic [7:0]    r_mix_out;
    logic          r_mix_valid;
    logic          r_muted;

`ifdef ECHO_FADE_EN
    localparam int            FW        = $clog2(FADE_STEP + 1);
    localparam logic [FW-1:0] FADE_LOAD = FW'(FADE_STEP);
    logic [3:0]    r_ramp;
    logic [FW-1:0] r_fade_cnt;
`else
    localparam int unused_fade_step = FADE_STEP;
`endif

    logic        w_tap_chg;
    logic [3:0]  w_gain_cl;
    logic [3:0]  w_g;
    logic [11:0] w_acc;
    logic        w_unused;

    assign w_tap_chg = (tap_sel != r_tap_q);
    assign w_gain_cl = (mix_gain > 4'd8) ? 4'd8 : mix_gain;

    // Ramp is capped by the live gain so a mid-fade gain cut never over-weights the wet path.
    always_comb begin
        w_g = w_gain_cl;
        case (r_state)
            ST_MUTE: w_g = 4'd0;
`ifdef ECHO_FADE_EN
            ST_FADE: w_g = (r_ramp < w_gain_cl) ? r_ramp : w_gain_cl;
`endif
            default: w_g = w_gain_cl;
        endcase
    end

    assign w_acc    = 12'(dry_in) * 12'(4'd8 - w_g) + 12'(wet_in) * 12'(w_g) + 12'd4;
    assign w_unused = ^{w_acc[11], w_acc[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_tap_q     <= 2'd0;
            r_mute_cnt  <= '0;
            r_mix_out   <= 8'd0;
            r_mix_valid <= 1'b0;
            r_muted     <= 1'b0;
`ifdef ECHO_FADE_EN
            r_ramp      <= 4'd0;
            r_fade_cnt  <= '0;
`endif
        end else begin
            r_tap_q     <= tap_sel;
            r_mix_valid <= sample_en;
            if (sample_en) begin
                r_mix_out <= w_acc[10:3];
            end
            case (r_state)
                ST_RUN: begin
                    if (w_tap_chg) begin
                        r_state    <= ST_MUTE;
                        r_mute_cnt <= MUTE_LOAD;
                        r_muted    <= 1'b1;
                    end
                end
                ST_MUTE: begin
                    if (w_tap_chg) begin
                        r_mute_cnt <= MUTE_LOAD;
                    end else if (sample_en) begin
                        r_mute_cnt <= r_mute_cnt - 1'b1;
                        if (r_mute_cnt == MW'(1)) begin
`ifdef ECHO_FADE_EN
                            r_state    <= ST_FADE;
                            r_ramp     <= 4'd0;
                            r_fade_cnt <= FADE_LOAD;
`else
                            r_state    <= ST_RUN;
                            r_muted    <= 1'b0;
`endif
                        end
                    end
                end
`ifdef ECHO_FADE_EN
                ST_FADE: begin
                    if (w_tap_chg) begin
                        r_state    <= ST_MUTE;
                        r_mute_cnt <= MUTE_LOAD;
                        r_ramp     <= 4'd0;
                    end else if (r_ramp >= w_gain_cl) begin
                        r_state    <= ST_RUN;
                        r_muted    <= 1'b0;
                    end else if (sample_en) begin
                        if (r_fade_cnt == FW'(1)) begin
                            r_ramp     <= r_ramp + 4'd1;
                            r_fade_cnt <= FADE_LOAD;
                        end else begin
                            r_fade_cnt <= r_fade_cnt - 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_RUN;
                    r_muted <= 1'b0;
                end
            endcase
        end
    end

    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;
    assign muted     = r_muted;

endmodule

// File: tb/tb_echo_mix_stage.sv
// Bench for echo_mix_stage: randomized and directed stimulus against a strobe-counting mix model.
module tb_echo_mix_stage;
    localparam int MUTE_N = 16;
    localparam int STEP_N = 4;
    localparam int BIG    = 100000;
`ifdef ECHO_FADE_EN
    localparam bit FADE_ON = 1'b1;
`else
    localparam bit FADE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sample_en = 1'b0;
    logic [7:0] dry_in = 8'd0;
    logic [7:0] wet_in = 8'd0;
    logic [1:0] tap_sel = 2'd0;
    logic [3:0] mix_gain = 4'd0;
    logic [7:0] mix_out;
    logic       mix_valid;
    logic       muted;

    int checks = 0;
    int errors = 0;

    // Model state: strobes since the last tap change, last tap seen, last mixed value.
    int m_cnt = BIG;
    int m_tap = 0;
    int m_out = 0;

    echo_mix_stage #(.MUTE_SAMPLES(MUTE_N), .FADE_STEP(STEP_N)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .dry_in(dry_in), .wet_in(wet_in),
        .tap_sel(tap_sel), .mix_gain(mix_gain), .mix_out(mix_out), .mix_valid(mix_valid),
        .muted(muted)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int clampg(input int gain);
        return (gain > 8) ? 8 : gain;
    endfunction

    function automatic int mix(input int d, input int w, input int g);
        return (d * (8 - g) + w * g + 4) / 8;
    endfunction

    function automatic int model_g(input int gain);
        int gc;
        int ramp;
        gc = clampg(gain);
        if (m_cnt < MUTE_N) return 0;
        if (!FADE_ON) return gc;
        ramp = (m_cnt - MUTE_N) / STEP_N;
        return (ramp < gc) ? ramp : gc;
    endfunction

    function automatic void model_reset();
        m_cnt = BIG;
        m_tap = 0;
        m_out = 0;
    endfunction

    // Drive one clock of inputs, advance the model, return expectations for after the edge.
    task automatic cyc(input logic se, input int d, input int w, input int t, input int gain,
                       output int exp_out, output logic exp_vld, output logic exp_mut);
        bit stepped;
        int fade_end;
        sample_en = se;
        dry_in    = d[7:0];
        wet_in    = w[7:0];
        tap_sel   = t[1:0];
        mix_gain  = gain[3:0];
        exp_vld   = se;
        if (se) m_out = mix(d, w, model_g(gain));
        exp_out = m_out;
        stepped = 1'b0;
        if (t != m_tap) m_cnt = 0;
        else if (se && m_cnt < BIG) begin
            m_cnt++;
            stepped = 1'b1;
        end
        m_tap = t;
        fade_end = MUTE_N + clampg(gain) * STEP_N;
        if (m_cnt < MUTE_N) exp_mut = 1'b1;
        else if (!FADE_ON) exp_mut = 1'b0;
        else exp_mut = (m_cnt < fade_end) || (stepped && m_cnt == fade_end);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (mix_out !== 8'd0) begin errors++; $display("FAIL reset_out got %0d want 0", mix_out); end
        checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mix_valid); end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL reset_muted got %b want 0", muted); end
        #10 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_sample();
        int eo; logic ev, em;
        cyc(1'b1, 100, 200, 0, 4, eo, ev, em);
        checks++; if (mix_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", mix_valid); end
        checks++; if (mix_out !== 8'd150) begin errors++; $display("FAIL single_out got %0d want 150", mix_out); end
        cyc(1'b0, 100, 200, 0, 4, eo, ev, em);
        checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", mix_valid); end
        checks++; if (mix_out !== 8'd150) begin errors++; $display("FAIL single_hold got %0d want 150", mix_out); end
    endtask

    task automatic test_gain_sweep();
        int gains[4] = '{0, 3, 8, 15};
        int wants[4] = '{100, 138, 200, 200};
        int eo; logic ev, em;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 100, 200, 0, gains[i], eo, ev, em);
            checks++;
            if (mix_out !== 8'(wants[i])) begin
                errors++; $display("FAIL sweep_g%0d got %0d want %0d", gains[i], mix_out, wants[i]);
            end
        end
        cyc(1'b1, 255, 255, 0, 5, eo, ev, em);
        checks++; if (mix_out !== 8'd255) begin errors++; $display("FAIL full_scale got %0d want 255", mix_out); end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 0, $urandom_range(0, 15), eo, ev, em);
            checks++; if (mix_out !== 8'(eo)) begin errors++; $display("FAIL sweep_rand got %0d want %0d", mix_out, eo); end
            checks++; if (muted !== 1'b0) begin errors++; $display("FAIL sweep_muted got %b want 0", muted); end
        end
    endtask

    task automatic test_mute_fade();
        int eo; logic ev, em;
        int n;
        cyc(1'b1, 0, 240, 2, 8, eo, ev, em);
        checks++; if (mix_out !== 8'd240) begin errors++; $display("FAIL mute_edge_out got %0d want 240", mix_out); end
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL mute_edge_muted got %b want 1", muted); end
        n = MUTE_N + (FADE_ON ? 8 * STEP_N : 0) + 3;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 0, 240, 2, 8, eo, ev, em);
            checks++; if (mix_out !== 8'(eo)) begin errors++; $display("FAIL mute_seq%0d got %0d want %0d", i, mix_out, eo); end
            checks++; if (muted !== em) begin errors++; $display("FAIL mute_flag%0d got %b want %b", i, muted, em); end
        end
        checks++; if (mix_out !== 8'd240) begin errors++; $display("FAIL mute_settled_out got %0d want 240", mix_out); end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL mute_settled_flag got %b want 0", muted); end
    endtask

    task automatic test_retrigger();
        int eo; logic ev, em;
        cyc(1'b1, 0, 240, 1, 8, eo, ev, em);
        for (int i = 0; i < MUTE_N + 3 * STEP_N + 1; i++) begin
            cyc(1'b1, 0, 240, 1, 8, eo, ev, em);
            checks++; if (mix_out !== 8'(eo)) begin errors++; $display("FAIL retrig_pre%0d got %0d want %0d", i, mix_out, eo); end
        end
        // Tap change while the ramp sits at 3 (fade build) or in RUN (no fade).
        cyc(1'b1, 0, 240, 3, 8, eo, ev, em);
        checks++; if (mix_out !== 8'(eo)) begin errors++; $display("FAIL retrig_edge got %0d want %0d", mix_out, eo); end
        checks++; if (muted !== 1'b1) begin errors++; $display("FAIL retrig_edge_muted got %b want 1", muted); end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 0, 240, 3, 8, eo, ev, em);
            checks++; if (mix_out !== 8'd0) begin errors++; $display("FAIL retrig_mute%0d got %0d want 0", i, mix_out); end
        end
        cyc(1'b1, 0, 240, 0, 8, eo, ev, em);
        for (int i = 0; i < MUTE_N; i++) begin
            cyc(1'b1, 0, 240, 0, 8, eo, ev, em);
            checks++; if (mix_out !== 8'd0) begin errors++; $display("FAIL remute%0d got %0d want 0", i, mix_out); end
            checks++; if (muted !== em) begin errors++; $display("FAIL remute_flag%0d got %b want %b", i, muted, em); end
        end
        for (int i = 0; i < 8 * STEP_N + 3; i++) begin
            cyc(1'b1, 0, 240, 0, 8, eo, ev, em);
            checks++; if (mix_out !== 8'(eo)) begin errors++; $display("FAIL refade%0d got %0d want %0d", i, mix_out, eo); end
            checks++; if (muted !== em) begin errors++; $display("FAIL refade_flag%0d got %b want %b", i, muted, em); end
        end
    endtask

    task automatic test_reset_mid_fade();
        int eo; logic ev, em;
        int d, w;
        cyc(1'b1, 0, 240, 2, 8, eo, ev, em);
        for (int i = 0; i < MUTE_N + 2 * STEP_N + 1; i++) cyc(1'b1, 0, 240, 2, 8, eo, ev, em);
        #2 rst_n = 1'b0;
        sample_en = 1'b0;
        tap_sel   = 2'd0;
        #1;
        checks++; if (mix_out !== 8'd0) begin errors++; $display("FAIL arst_out got %0d want 0", mix_out); end
        checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", mix_valid); end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL arst_muted got %b want 0", muted); end
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        d = $urandom_range(0, 255);
        w = $urandom_range(0, 255);
        cyc(1'b1, d, w, 0, 8, eo, ev, em);
        checks++; if (mix_out !== 8'(mix(d, w, 8))) begin errors++; $display("FAIL arst_next got %0d want %0d", mix_out, mix(d, w, 8)); end
        checks++; if (mix_valid !== 1'b1) begin errors++; $display("FAIL arst_next_valid got %b want 1", mix_valid); end
        checks++; if (muted !== 1'b0) begin errors++; $display("FAIL arst_next_muted got %b want 0", muted); end
    endtask

    task automatic test_random();
        int eo; logic ev, em;
        int tap;
        int gain;
        tap = m_tap;
        for (int s = 0; s < 3; s++) begin
            gain = $urandom_range(0, 15);
            for (int i = 0; i < 260; i++) begin
                logic se;
                se = ($urandom_range(0, 9) < 7);
                if (i < 200) begin
                    if ($urandom_range(0, 29) == 0) tap = (tap + $urandom_range(1, 3)) % 4;
                end else begin
                    se = 1'b1;
                end
                cyc(se, $urandom_range(0, 255), $urandom_range(0, 255), tap, gain, eo, ev, em);
                checks++; if (mix_valid !== ev) begin errors++; $display("FAIL rand_valid s%0d c%0d got %b want %b", s, i, mix_valid, ev); end
                checks++; if (mix_out !== 8'(eo)) begin errors++; $display("FAIL rand_out s%0d c%0d got %0d want %0d", s, i, mix_out, eo); end
                checks++; if (muted !== em) begin errors++; $display("FAIL rand_muted s%0d c%0d got %b want %b", s, i, muted, em); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_gain_sweep();
        test_mute_fade();
        test_retrigger();
        test_reset_mid_fade();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
